// File: rtl/wb_regfile_pkg.sv
// Shared sizing constants for the write-back stage and register file.
package wb_regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int REG_N  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_array.sv
// Register storage: REG_N x DATA_W, one synchronous write port, two asynchronous read ports.
module regfile_array
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [REG_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back latch, R0 masking and read-port forwarding in front of the register array.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_pend
);

    logic              r_pend_v_p1;
    logic [ADDR_W-1:0] r_pend_a_p1;
    logic [DATA_W-1:0] r_pend_d_p1;

    logic [DATA_W-1:0] w_arr_rs;
    logic [DATA_W-1:0] w_arr_rt;

    // Read priority: R0 is zero, then the pending write, then the array.
    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] addr,
        input logic              pend_v,
        input logic [ADDR_W-1:0] pend_a,
        input logic [DATA_W-1:0] pend_d,
        input logic [DATA_W-1:0] arr_d
    );
        if (addr == REG_ZERO) begin
            return '0;
        end else if (pend_v && (pend_a == addr)) begin
            return pend_d;
        end else begin
            return arr_d;
        end
    endfunction

    // Capture stage: the latch commits every edge it is valid, so a stalled edge
    // always leaves it empty while holding address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_v_p1 <= 1'b0;
            r_pend_a_p1 <= '0;
            r_pend_d_p1 <= '0;
        end else if (!stall) begin
            r_pend_v_p1 <= wb_en && (wb_addr != REG_ZERO);
            r_pend_a_p1 <= wb_addr;
            r_pend_d_p1 <= wb_data;
        end else begin
            r_pend_v_p1 <= 1'b0;
        end
    end

    // Commit stage
    regfile_array u_array (
        .clk       (clk),
        .rst       (rst),
        .i_we      (r_pend_v_p1),
        .i_waddr   (r_pend_a_p1),
        .i_wdata   (r_pend_d_p1),
        .i_raddr_a (rs_addr),
        .i_raddr_b (rt_addr),
        .o_rdata_a (w_arr_rs),
        .o_rdata_b (w_arr_rt)
    );

    assign rs_data = f_read(rs_addr, r_pend_v_p1, r_pend_a_p1, r_pend_d_p1, w_arr_rs);
    assign rt_data = f_read(rt_addr, r_pend_v_p1, r_pend_a_p1, r_pend_d_p1, w_arr_rt);
    assign wb_pend = r_pend_v_p1;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: architectural-visibility model, directed and random stimulus.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        wb_pend;

    wb_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .stall   (stall),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wb_pend (wb_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [15:0] rs_exp;
        logic [15:0] rt_exp;
        logic        pend_exp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;

    // Model: value each register shows to decode in the cycle after its capture edge.
    logic [15:0] model [16];
    logic        m_pend;
    int          cur_tag;

    function automatic logic [15:0] m_read(input logic [3:0] a);
        return (a == 4'd0) ? 16'h0000 : model[a];
    endfunction

    task automatic chk(input string nm, input int t, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s test%0d got=%h exp=%h at %0t", nm, t, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the edge, push what the ports must show this cycle,
    // then advance the model by what the coming edge captures.
    task automatic cycle(input logic en, input logic [3:0] a, input logic [15:0] d,
                         input logic st, input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
        stall   = st;
        rs_addr = ra;
        rt_addr = rb;
        e.tag      = cur_tag;
        e.rs_exp   = m_read(ra);
        e.rt_exp   = m_read(rb);
        e.pend_exp = m_pend;
        sb.push_back(e);
        if (!st && en && (a != 4'd0)) begin
            model[a] = d;
            m_pend   = 1'b1;
        end else begin
            m_pend   = 1'b0;
        end
    endtask

    task automatic reset_cycle(input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        wb_en   = 1'b0;
        stall   = 1'b0;
        rs_addr = ra;
        rt_addr = rb;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        m_pend     = 1'b0;
        e.tag      = cur_tag;
        e.rs_exp   = 16'h0000;
        e.rt_exp   = 16'h0000;
        e.pend_exp = 1'b0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rs_data", e.tag, rs_data, e.rs_exp);
            chk("rt_data", e.tag, rt_data, e.rt_exp);
            chk("wb_pend", e.tag, {15'd0, wb_pend}, {15'd0, e.pend_exp});
        end
    end

    initial begin
        logic [3:0]  ra, rb, a, last_a;
        logic [15:0] d;
        logic        en, st;
        int          guard;

        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        stall = 1'b0; rs_addr = '0; rt_addr = '0;
        m_pend = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;

        cur_tag = 0;
        reset_cycle(4'd1, 4'd15);
        reset_cycle(4'd3, 4'd0);

        // Test 1: reset while a write to R3 is pending
        cur_tag = 1;
        cycle(1'b1, 4'd1, 16'h1111, 1'b0, 4'd1, 4'd3);
        cycle(1'b1, 4'd3, 16'h3333, 1'b0, 4'd1, 4'd3);
        reset_cycle(4'd3, 4'd1);
        for (int i = 1; i < 16; i++) cycle(1'b0, 4'd0, 16'h0, 1'b0, i[3:0], 4'd3);

        // Test 2: write R5, read it every cycle
        cur_tag = 2;
        cycle(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd5, 4'd5);
        repeat (3) cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd5, 4'd5);

        // Test 3: writes to R0 are dropped
        cur_tag = 3;
        cycle(1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 4'd0);
        repeat (2) cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5);

        // Test 4: back-to-back writes to R2
        cur_tag = 4;
        cycle(1'b1, 4'd2, 16'h0001, 1'b0, 4'd2, 4'd2);
        cycle(1'b1, 4'd2, 16'h0002, 1'b0, 4'd2, 4'd2);
        repeat (3) cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd2, 4'd2);

        // Test 5: stall holds off a new write to R7
        cur_tag = 5;
        cycle(1'b1, 4'd7, 16'h00FF, 1'b0, 4'd7, 4'd7);
        repeat (3) cycle(1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 4'd7);
        cycle(1'b1, 4'd7, 16'hAAAA, 1'b0, 4'd7, 4'd7);
        repeat (2) cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd7, 4'd7);

        // Test 6: random traffic
        cur_tag = 6;
        last_a  = 4'd1;
        for (int n = 0; n < 10000; n++) begin
            en = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) == 0) ? last_a : 4'($urandom_range(0, 15));
            d  = 16'($urandom);
            st = ($urandom_range(0, 4) == 0);
            ra = ($urandom_range(0, 1) == 0) ? last_a : 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
            if (n == 5000) begin
                reset_cycle(ra, rb);
            end else begin
                cycle(en, a, d, st, ra, rb);
            end
            last_a = a;
        end

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
